mtimer_bank: RTL

MTIMER_BANK -- requirements
Module: mtimer_bank

---
 rtl/mtimer_pkg.sv | 34 +++
 rtl/mtimer_prescaler.sv | 34 +++
 rtl/mtimer_bank.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mtimer_pkg.sv
// Shared constants for the machine timer bank: register offsets, CTRL field
// positions and the byte-enable merge used by every 64-bit register write.
package mtimer_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] CTRL_ADDR     = 16'hBFF0;
    localparam logic [15:0] MTIME_ADDR    = 16'hBFF8;

    // msip and mtimecmp each own a 16 KiB window selected by addr[15:14]
    localparam logic [15:0] REGION_MASK   = 16'hC000;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_DIV_LSB  = 16;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP,
        REG_CTRL,
        REG_MTIME
    } reg_sel_e;

    function automatic logic [63:0] apply_be(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  be);
        logic [63:0] res;
        for (int b = 0; b < 8; b++) begin
            res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Tick generator: counts 0..divider while enabled and pulses on the terminal
// value; testmode forces a tick every cycle without disturbing the count.
module mtimer_prescaler #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic                 clear,
    input  logic                 testmode,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 terminal;

    assign terminal = enable && (cnt_q == divider);
    assign tick     = testmode || terminal;

    // Counter holds while disabled; a CTRL write restarts the period from zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (terminal) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mtimer_bank.sv
// Machine timer bank: shared 64-bit mtime with programmable prescaler,
// per-hart mtimecmp/msip, and a single-cycle-latency register port.
module mtimer_bank
    import mtimer_pkg::*;
#(
    parameter int unsigned NR_CORES  = 1,
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned RESET_DIV = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                testmode_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [15:0]         addr_i,
    input  logic [63:0]         wdata_i,
    input  logic [7:0]          be_i,
    output logic                gnt_o,
    output logic                rvalid_o,
    output logic [63:0]         rdata_o,
    output logic                err_o,
    output logic [NR_CORES-1:0] timer_irq_o,
    output logic [NR_CORES-1:0] ipi_o,
    output logic                tick_o
);

    localparam logic [11:0]          NR_CORES_W = 12'(NR_CORES);
    localparam logic [DIV_WIDTH-1:0] DIV_RESET  = DIV_WIDTH'(RESET_DIV);

    logic [63:0]          mtime_q;
    logic [63:0]          mtimecmp_q [NR_CORES];
    logic [NR_CORES-1:0]  msip_q;
    logic                 enable_q;
    logic [DIV_WIDTH-1:0] divider_q;
    logic [NR_CORES-1:0]  timer_irq_q;
    logic                 tick_q;
    logic                 rvalid_q;
    logic                 err_q;
    logic [63:0]          rdata_q;

    reg_sel_e    sel;
    logic [3:0]  hart_idx;
    logic        wr_en;
    logic        wr_mtime;
    logic        wr_cmp;
    logic        wr_msip;
    logic        wr_ctrl;
    logic        msip_lane_hi;
    logic        msip_be;
    logic        msip_bit;
    logic [63:0] ctrl_img;
    logic [63:0] ctrl_wr;
    logic [63:0] rd_data;
    logic        tick;
    logic        unused_ctrl_wr;

    // Address decode: exact match for CTRL/mtime, aligned per-hart windows otherwise
    always_comb begin
        sel      = REG_NONE;
        hart_idx = '0;
        if (addr_i == CTRL_ADDR) begin
            sel = REG_CTRL;
        end else if (addr_i == MTIME_ADDR) begin
            sel = REG_MTIME;
        end else if (((addr_i & REGION_MASK) == MSIP_BASE) && (addr_i[1:0] == 2'b00)
                     && (addr_i[13:2] < NR_CORES_W)) begin
            sel      = REG_MSIP;
            hart_idx = addr_i[5:2];
        end else if (((addr_i & REGION_MASK) == MTIMECMP_BASE) && (addr_i[2:0] == 3'b000)
                     && (addr_i[13:3] < NR_CORES_W[10:0])) begin
            sel      = REG_MTIMECMP;
            hart_idx = addr_i[6:3];
        end
    end

    assign wr_en    = req_i && we_i;
    assign wr_mtime = wr_en && (sel == REG_MTIME);
    assign wr_cmp   = wr_en && (sel == REG_MTIMECMP);
    assign wr_msip  = wr_en && (sel == REG_MSIP);
    assign wr_ctrl  = wr_en && (sel == REG_CTRL);

    // msip is 32 bits wide, so addr[2] picks which half of the bus carries it
    assign msip_lane_hi = addr_i[2];
    assign msip_be      = msip_lane_hi ? be_i[4]     : be_i[0];
    assign msip_bit     = msip_lane_hi ? wdata_i[32] : wdata_i[0];

    // CTRL as it appears on the bus, used for reads and as the base of byte-merged writes
    always_comb begin
        ctrl_img                              = '0;
        ctrl_img[CTRL_EN_BIT]                 = enable_q;
        ctrl_img[CTRL_DIV_LSB +: DIV_WIDTH]   = divider_q;
    end

    assign ctrl_wr        = apply_be(ctrl_img, wdata_i, be_i);
    assign unused_ctrl_wr = ^ctrl_wr;

    // Read mux, sampled from register state as it stands in the grant cycle
    always_comb begin
        rd_data = '0;
        case (sel)
            REG_MSIP: begin
                for (int h = 0; h < NR_CORES; h++) begin
                    if (hart_idx == 4'(h)) begin
                        rd_data = msip_lane_hi ? (64'(msip_q[h]) << 32) : 64'(msip_q[h]);
                    end
                end
            end
            REG_MTIMECMP: begin
                for (int h = 0; h < NR_CORES; h++) begin
                    if (hart_idx == 4'(h)) begin
                        rd_data = mtimecmp_q[h];
                    end
                end
            end
            REG_CTRL:  rd_data = ctrl_img;
            REG_MTIME: rd_data = mtime_q;
            default:   rd_data = '0;
        endcase
    end

    mtimer_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable   (enable_q),
        .divider  (divider_q),
        .clear    (wr_ctrl),
        .testmode (testmode_i),
        .tick     (tick)
    );

    // mtime: a bus write takes priority and swallows a coincident tick
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= tick && !wr_mtime;
            if (wr_mtime) begin
                mtime_q <= apply_be(mtime_q, wdata_i, be_i);
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
            end
        end
    end

    // Per-hart compare registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int h = 0; h < NR_CORES; h++) begin
                mtimecmp_q[h] <= '1;
            end
        end else begin
            for (int h = 0; h < NR_CORES; h++) begin
                if (wr_cmp && (hart_idx == 4'(h))) begin
                    mtimecmp_q[h] <= apply_be(mtimecmp_q[h], wdata_i, be_i);
                end
            end
        end
    end

    // Per-hart software interrupt pending bits
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            msip_q <= '0;
        end else begin
            for (int h = 0; h < NR_CORES; h++) begin
                if (wr_msip && msip_be && (hart_idx == 4'(h))) begin
                    msip_q[h] <= msip_bit;
                end
            end
        end
    end

    // Prescaler configuration
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_q  <= 1'b1;
            divider_q <= DIV_RESET;
        end else if (wr_ctrl) begin
            enable_q  <= ctrl_wr[CTRL_EN_BIT];
            divider_q <= ctrl_wr[CTRL_DIV_LSB +: DIV_WIDTH];
        end
    end

    // Timer interrupts follow the compare result with one cycle of delay
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_irq_q <= '0;
        end else begin
            for (int h = 0; h < NR_CORES; h++) begin
                timer_irq_q[h] <= (mtime_q >= mtimecmp_q[h]);
            end
        end
    end

    // Response channel: every grant gets exactly one response the next cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= req_i;
            err_q    <= req_i && (sel == REG_NONE);
            rdata_q  <= (req_i && !we_i) ? rd_data : '0;
        end
    end

    assign gnt_o       = req_i;
    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign timer_irq_o = timer_irq_q;
    assign ipi_o       = msip_q;
    assign tick_o      = tick_q;

endmodule
